// File: rtl/pusch_pkg.sv
// Shared PUSCH transmit-chain definitions: CRC width, default buffer depth and the
// crc_append state encoding.
package pusch_pkg;

    localparam int unsigned CRC_W            = 16;
    localparam int unsigned MAX_BITS_DEFAULT = 1024;

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StWaitCrc,
        StSendData,
        StSendCrc
    } state_e;

endpackage

// File: rtl/crc_append_bitbuf.sv
// Single-port DEPTH x 1 bit buffer with write enable and registered read.
// The address is shared; the caller never asserts we_i and re_i together.
module crc_append_bitbuf #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              wdata_i,
    output logic              rdata_o
);

    logic mem_q [DEPTH];
    logic rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= 1'b0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/crc_append.sv
// Buffers a serial payload, waits for its CRC-16 word, then emits payload + CRC (MSB first).
// Optional macro CRC_APPEND_READY_EN adds an OUT_READY back-pressure input.
module crc_append
    import pusch_pkg::*;
#(
    parameter int unsigned MAX_BITS = MAX_BITS_DEFAULT,
    parameter int unsigned CNT_W    = $clog2(MAX_BITS + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             DATA_IN,
    input  logic             DATA_VALID,
    input  logic [CRC_W-1:0] CRC_IN,
    input  logic             CRC_VALID,
`ifdef CRC_APPEND_READY_EN
    input  logic             OUT_READY,
`endif
    output logic             DATA_OUT,
    output logic             OUT_VALID,
    output logic             OUT_LAST,
    output logic             BUSY,
    output logic             ERR
);

    localparam int unsigned ADDR_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
    localparam int unsigned IDX_W  = $clog2(CRC_W);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   rd_q, rd_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic               err_q, err_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               busy_q;

    logic               buf_we, buf_re, buf_rdata;
    logic [ADDR_W-1:0]  buf_addr;
    logic               advance;

`ifdef CRC_APPEND_READY_EN
    assign advance = OUT_READY;
`else
    assign advance = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        rd_d     = rd_q;
        idx_d    = idx_q;
        crc_d    = crc_q;
        err_d    = err_q;
        buf_we   = 1'b0;
        buf_re   = 1'b0;
        buf_addr = '0;

        // Bits arriving while a frame is queued or being sent are dropped.
        if (DATA_VALID && (state_q inside {StWaitCrc, StSendData, StSendCrc})) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (DATA_VALID) begin
                    buf_we  = 1'b1;
                    len_d   = CNT_W'(1);
                    state_d = StCollect;
                end
            end
            StCollect: begin
                if (DATA_VALID) begin
                    if (len_q == CNT_W'(MAX_BITS)) begin
                        err_d = 1'b1;
                    end else begin
                        buf_we   = 1'b1;
                        buf_addr = len_q[ADDR_W-1:0];
                        len_d    = len_q + CNT_W'(1);
                    end
                end else begin
                    state_d = StWaitCrc;
                end
            end
            StWaitCrc: begin
                if (CRC_VALID) begin
                    crc_d   = CRC_IN;
                    rd_d    = '0;
                    buf_re  = 1'b1;
                    state_d = StSendData;
                end
            end
            StSendData: begin
                if (advance) begin
                    if (rd_q == len_q - CNT_W'(1)) begin
                        idx_d   = IDX_W'(CRC_W - 1);
                        state_d = StSendCrc;
                    end else begin
                        rd_d     = rd_q + CNT_W'(1);
                        buf_re   = 1'b1;
                        buf_addr = rd_d[ADDR_W-1:0];
                    end
                end
            end
            StSendCrc: begin
                if (advance) begin
                    if (idx_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        out_valid_d = state_d inside {StSendData, StSendCrc};
        out_last_d  = (state_d == StSendCrc) && (idx_d == '0);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= StIdle;
            len_q       <= '0;
            rd_q        <= '0;
            idx_q       <= '0;
            crc_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            rd_q        <= rd_d;
            idx_q       <= idx_d;
            crc_q       <= crc_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= (state_d != StIdle);
        end
    end

    crc_append_bitbuf #(
        .DEPTH  (MAX_BITS),
        .ADDR_W (ADDR_W)
    ) u_bitbuf (
        .clk_i   (CLK),
        .rst_i   (RST),
        .we_i    (buf_we),
        .re_i    (buf_re),
        .addr_i  (buf_addr),
        .wdata_i (DATA_IN),
        .rdata_o (buf_rdata)
    );

    // Payload bits come straight from the buffer's read register; CRC bits from the latch.
    assign DATA_OUT  = out_valid_q & ((state_q == StSendCrc) ? crc_q[idx_q] : buf_rdata);
    assign OUT_VALID = out_valid_q;
    assign OUT_LAST  = out_last_q;
    assign BUSY      = busy_q;
    assign ERR       = err_q;

endmodule

// File: doc/crc_append.md
Name: crc_append

Overview:
- Sits directly downstream of the bit-serial CRC-16 generator in the PUSCH transmit chain.
- Buffers the transport-block bits as they stream into the CRC generator.
- Waits for the generator's 16-bit CRC word, then emits one serial stream: payload bits in arrival order, followed by the 16 CRC bits.
- The output feeds the next bit-serial stage (segmentation/scrambling).

Parameters:
- MAX_BITS, 1024: buffer depth in bits; the largest payload accepted per frame.
- CNT_W, $clog2(MAX_BITS+1): width of the length and read counters.

Ports:
- CLK  input  1  single clock; everything samples on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- DATA_IN  input  1  payload bit; the same bit driven to the CRC generator's DATA.
- DATA_VALID  input  1  payload strobe; the same signal as the CRC generator's ACTIVE.
- CRC_IN  input  16  CRC word from the generator's data_out.
- CRC_VALID  input  1  CRC word qualifier, from the generator's Valid.
- DATA_OUT  output  1  serial output bit.
- OUT_VALID  output  1  DATA_OUT is valid this cycle.
- OUT_LAST  output  1  marks the final CRC bit of the frame.
- BUSY  output  1  high from the first payload bit until the cycle after OUT_LAST.
- ERR  output  1  sticky; set on overflow or on input during the send phase; cleared only by RST.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; the buffer contents are don't-care.
- RST asserted mid-frame aborts the frame immediately. Outputs go to 0 in the same cycle, asynchronously.
- State machine: IDLE, COLLECT, WAIT_CRC, SEND_DATA, SEND_CRC.
- IDLE:
  - DATA_VALID=1: write DATA_IN at address 0, set len=1, go to COLLECT.
  - BUSY rises in the cycle after that first bit.
- COLLECT:
  - Each cycle with DATA_VALID=1: write at address len, then len++.
  - Overflow: once len==MAX_BITS, further bits are dropped and ERR is set. The frame still completes with len=MAX_BITS.
  - DATA_VALID=0: go to WAIT_CRC.
- WAIT_CRC:
  - CRC_VALID=1: latch CRC_IN into crc_q, clear rd=0, go to SEND_DATA.
  - CRC_VALID pulses arriving in IDLE or COLLECT are ignored.
  - The generator holds Valid high for several cycles; only the first sample in WAIT_CRC is used.
- SEND_DATA:
  - Each cycle: OUT_VALID=1, DATA_OUT=mem[rd], rd++.
  - After rd==len-1 is emitted, go to SEND_CRC with bit index 15.
  - The first payload bit appears in the cycle after CRC_VALID is sampled, i.e. latency 1.
- SEND_CRC:
  - DATA_OUT=crc_q[idx], sent MSB first (crc_q[15] first, crc_q[0] last).
  - OUT_LAST=1 with crc_q[0]; then return to IDLE.
- Output timing:
  - OUT_VALID is continuous for len+16 cycles.
  - OUT_VALID, OUT_LAST and DATA_OUT are registered.
- DATA_VALID=1 during WAIT_CRC, SEND_DATA or SEND_CRC: the bit is dropped and ERR is set. The frame in flight is unaffected.
- Back-to-back frames: a new DATA_VALID is accepted in IDLE, including the cycle after OUT_LAST.
- Buffer: single-port bit memory, MAX_BITS x 1. Write and read never overlap, because collect and send phases are exclusive.

Optional Feature:
- Macro: CRC_APPEND_READY_EN.
- Defined: adds port OUT_READY (input, 1).
  - In SEND_DATA and SEND_CRC, rd/idx advance only when OUT_VALID && OUT_READY.
  - DATA_OUT, OUT_VALID and OUT_LAST hold stable while OUT_READY=0.
- Undefined: no OUT_READY port; the downstream is always ready and the output never stalls.

Decomposition:
- Shared package pusch_pkg:
  - CRC_W=16
  - the state enum typedef (IDLE..SEND_CRC)
  - the MAX_BITS default constant
- One sub-module: crc_append_bitbuf, a parameterised MAX_BITS x 1 single-port register/RAM with a write enable and a registered read.
- The FSM, counters and CRC latch stay in the top level.

Test Plan:
- Basic frame:
  - Stimulus: 8 bits 1,0,1,0,0,1,0,1 (0xA5); 4 idle cycles; CRC_IN=16'h1234 with CRC_VALID.
  - Required response: 24 contiguous OUT_VALID cycles; bits 10100101 then 0001001000110100; OUT_LAST on the 24th; BUSY falls after it.
- Overflow:
  - Stimulus: MAX_BITS=16, 20 bits streamed.
  - Required response: ERR=1; exactly 16 payload bits, then 16 CRC bits.
- CRC_VALID held high for 3 cycles (generator behaviour):
  - Required response: single latch; no repeated or garbled CRC bits.
- Input during send phase:
  - Stimulus: DATA_VALID pulses mid-SEND_DATA.
  - Required response: ERR=1; output stream identical to the basic frame.
- RST pulse mid-SEND_DATA:
  - Required response: OUT_VALID=0 immediately; next frame (1 bit of 1, CRC 16'hFFFF) emits 17 ones with OUT_LAST on the 17th.
- With CRC_APPEND_READY_EN:
  - Stimulus: OUT_READY toggled 1,0,0,1 through the basic frame.
  - Required response: same 24-bit sequence; DATA_OUT stable across stalls.
